// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register unit beside the execute stage.
//   Holds the architectural HI/LO pair, performs single-cycle 64-bit MULT/MULTU,
//   and runs a radix-2 restoring divider (DIV/DIVU). A stall request is raised
//   while a division is in progress.
//
// Ports:
//   clk        pipeline clock
//   rstn       asynchronous reset, active-high (1 = reset)
//   stall      pipeline stall; requests are not accepted while 1
//   flush      pipeline flush; aborts a running division, drops idle requests
//   whilo      MTHI/MTLO write of hi_in/lo_in
//   hi_in      HI write data
//   lo_in      LO write data
//   start_mul  MULT/MULTU request
//   start_div  DIV/DIVU request
//   op_signed  1 = signed operation
//   src1       multiplicand / dividend
//   src2       multiplier / divisor
//   hi, lo     architectural HI/LO values
//   stall_req  stall request while the divider is busy
//   div_done   one-cycle pulse when a division result is written
//
// Build option:
//   HILO_BYPASS_EN  when defined, an accepted whilo/start_mul write is visible
//                   on hi/lo in the same cycle. Division results never bypass.

module hilo_muldiv #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             flush,
  input  logic             whilo,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall_req,
  output logic             div_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned      CW   = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0]    LAST = CW'(DIV_ITERS - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0]   dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;   // partial remainder
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               done_q, done_d;

  logic               accept;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [WIDTH-1:0]   step_rem, step_quo;

  assign accept = (state_q == IDLE) && !stall && !flush;

  // Magnitudes for the divider; unsigned operands pass through untouched.
  assign a_abs = (op_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign b_abs = (op_signed && src2[WIDTH-1]) ? -src2 : src2;

  // Extend to 2*WIDTH so one unsigned multiply yields both signed and
  // unsigned products in the low 2*WIDTH bits.
  assign mul_a = op_signed ? {{WIDTH{src1[WIDTH-1]}}, src1} : {{WIDTH{1'b0}}, src1};
  assign mul_b = op_signed ? {{WIDTH{src2[WIDTH-1]}}, src2} : {{WIDTH{1'b0}}, src2};
  assign prod  = mul_a * mul_b;

  // Restoring step: the shifted remainder is below 2*divisor, so the trial
  // difference fits in WIDTH+1 bits and its MSB is the borrow.
  assign trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign qbit     = !trial[WIDTH];
  assign step_rem = qbit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign step_quo = {dvd_q[WIDTH-2:0], qbit};

  // Deliberately independent of the stall input to avoid a loop through
  // the pipeline's stall logic.
  assign stall_req = ((state_q == IDLE) && start_div) || (state_q == RUN);
  assign div_done  = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (start_div) begin
            if (src2 == '0) begin
              hi_d    = src1;
              lo_d    = '1;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              dvd_d   = a_abs;
              dvs_d   = b_abs;
              qneg_d  = op_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
              rneg_d  = op_signed && src1[WIDTH-1];
              rem_d   = '0;
              cnt_d   = '0;
              state_d = RUN;
            end
          end else if (start_mul) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (whilo) begin
            hi_d = hi_in;
            lo_d = lo_in;
          end
        end
      end

      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          dvd_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            lo_d    = qneg_q ? -step_quo : step_quo;
            hi_d    = rneg_q ? -step_rem : step_rem;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (flush || !stall) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef HILO_BYPASS_EN
  always_comb begin
    hi = hi_q;
    lo = lo_q;
    if (accept && !start_div && (start_mul || whilo)) begin
      hi = hi_d;
      lo = lo_d;
    end
  end
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: the driver computes expectations from
// plain 64-bit arithmetic and queues them by cycle; the monitor checks them
// on the falling edge, together with div_done every cycle.

module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, whilo = 1'b0;
  logic        start_mul = 1'b0, start_div = 1'b0, op_signed = 1'b0;
  logic [31:0] hi_in = '0, lo_in = '0, src1 = '0, src2 = '0;
  logic [31:0] hi, lo;
  logic        stall_req, div_done;

  hilo_muldiv #(.WIDTH(32), .DIV_ITERS(32)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .whilo(whilo),
    .hi_in(hi_in), .lo_in(lo_in), .start_mul(start_mul), .start_div(start_div),
    .op_signed(op_signed), .src1(src1), .src2(src2), .hi(hi), .lo(lo),
    .stall_req(stall_req), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    bit          chk_hl;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          chk_s;
    bit          sreq;
    bit          done;
    string       name;
  } exp_t;

  exp_t        expq[$];
  int unsigned vectors = 0, miscompares = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  function automatic void push(int unsigned at, bit chk_hl, logic [31:0] h, logic [31:0] l,
                               bit chk_s, bit s, bit done, string nm);
    exp_t e;
    e.at = at; e.chk_hl = chk_hl; e.hi = h; e.lo = l;
    e.chk_s = chk_s; e.sreq = s; e.done = done; e.name = nm;
    expq.push_back(e);
  endfunction

  function automatic void push_hl(int unsigned at, logic [31:0] h, logic [31:0] l, string nm);
    push(at, 1'b1, h, l, 1'b0, 1'b0, 1'b0, nm);
  endfunction

  function automatic void push_s(int unsigned at, bit s, string nm);
    push(at, 1'b0, '0, '0, 1'b1, s, 1'b0, nm);
  endfunction

  function automatic void push_done(int unsigned at, string nm);
    push(at, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, nm);
  endfunction

  // Reference model: plain 64-bit arithmetic.
  function automatic void mul_ref(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
    longint unsigned p;
    if (sg) p = longint'($signed(a)) * longint'($signed(b));
    else    p = {32'b0, a} * {32'b0, b};
    h = p[63:32];
    l = p[31:0];
  endfunction

  function automatic void div_ref(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
    longint          sq, sr;
    longint unsigned uq, ur;
    if (b == 0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else if (sg) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      l = sq[31:0];
      h = sr[31:0];
    end else begin
      uq = {32'b0, a} / {32'b0, b};
      ur = {32'b0, a} % {32'b0, b};
      l = uq[31:0];
      h = ur[31:0];
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    bit exp_done;
    exp_done = 1'b0;
    for (int i = int'(expq.size()) - 1; i >= 0; i--) begin
      if (expq[i].at < cyc) begin
        vectors++; miscompares++;
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                 expq[i].name, expq[i].at, cyc);
        expq.delete(i);
      end else if (expq[i].at == cyc) begin
        if (expq[i].chk_hl) begin
          vectors++;
          if (hi !== expq[i].hi || lo !== expq[i].lo) begin
            miscompares++;
            $display("FAIL %s: cycle %0d hi/lo got %h/%h expected %h/%h",
                     expq[i].name, cyc, hi, lo, expq[i].hi, expq[i].lo);
          end
        end
        if (expq[i].chk_s) begin
          vectors++;
          if (stall_req !== expq[i].sreq) begin
            miscompares++;
            $display("FAIL %s: cycle %0d stall_req got %b expected %b",
                     expq[i].name, cyc, stall_req, expq[i].sreq);
          end
        end
        if (expq[i].done) exp_done = 1'b1;
        expq.delete(i);
      end
    end
    vectors++;
    if (div_done !== exp_done) begin
      miscompares++;
      $display("FAIL div_done: cycle %0d got %b expected %b", cyc, div_done, exp_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input bit is_mul, input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hin, input logic [31:0] lin,
                          input bit both, input string nm);
    int unsigned c;
    logic [31:0] eh, el;
    c = cyc;
    if (is_mul) mul_ref(sg, a, b, eh, el);
    else begin eh = hin; el = lin; end
    start_mul = is_mul; whilo = !is_mul || both; op_signed = sg;
    src1 = a; src2 = b; hi_in = hin; lo_in = lin;
    push_s(c, 1'b0, {nm, "_sreq"});
`ifdef HILO_BYPASS_EN
    push_hl(c, eh, el, {nm, "_bypass"});
`else
    push_hl(c, m_hi, m_lo, {nm, "_old"});
`endif
    push_hl(c + 1, eh, el, nm);
    tick();
    start_mul = 1'b0; whilo = 1'b0;
    m_hi = eh; m_lo = el;
    tick();
  endtask

  task automatic do_ignored(input int unsigned kind);
    int unsigned c;
    c = cyc;
    stall = 1'b1;
    op_signed = 1'($urandom_range(0, 1));
    src1 = $urandom; src2 = $urandom; hi_in = $urandom; lo_in = $urandom;
    start_div = (kind == 0); start_mul = (kind == 1); whilo = (kind == 2);
    push_hl(c, m_hi, m_lo, "stalled_req_same");
    push_hl(c + 1, m_hi, m_lo, "stalled_req_next");
    tick();
    start_div = 1'b0; start_mul = 1'b0; whilo = 1'b0; stall = 1'b0;
    tick();
  endtask

  // fl != 0: flush in run cycle fl. ds: stall cycles while in DONE.
  task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input bit with_wr, input int unsigned fl, input int unsigned ds,
                        input string nm);
    int unsigned c, d;
    logic [31:0] eh, el;
    c = cyc;
    div_ref(sg, a, b, eh, el);
    d = c + 1 + ((b == 0) ? 0 : 32);
    start_div = 1'b1; op_signed = sg; src1 = a; src2 = b;
    whilo = with_wr; hi_in = $urandom; lo_in = $urandom;
    if (fl != 0) begin
      for (int unsigned k = 0; k <= fl; k++) push_s(c + k, 1'b1, {nm, "_sreq_run"});
      push_s(c + fl + 1, 1'b0, {nm, "_sreq_flushed"});
      push_hl(c + fl + 1, m_hi, m_lo, {nm, "_flush_hilo"});
      push_hl(c + 34, m_hi, m_lo, {nm, "_flush_hilo_late"});
      tick();
      whilo = 1'b0;
      while (cyc < c + fl) tick();
      flush = 1'b1; start_div = 1'b0;
      tick();
      flush = 1'b0;
      while (cyc < c + 35) tick();
    end else begin
      for (int unsigned t = c; t < d; t++) push_s(t, 1'b1, {nm, "_sreq_busy"});
      for (int unsigned t = d; t <= d + ds; t++) push_s(t, 1'b0, {nm, "_sreq_done"});
      push_hl(d - 1, m_hi, m_lo, {nm, "_pre"});
      push_done(d, nm);
      push_hl(d, eh, el, nm);
      push_hl(d + ds, eh, el, {nm, "_held"});
      tick();
      whilo = 1'b0;
      while (cyc < d) tick();
      if (ds != 0) begin
        stall = 1'b1;
        repeat (ds) tick();
        stall = 1'b0;
      end
      tick();
      start_div = 1'b0;
      push_s(cyc, 1'b0, {nm, "_sreq_idle"});
      m_hi = eh; m_lo = el;
      tick();
    end
  endtask

  task automatic do_reset_mid();
    int unsigned c;
    c = cyc;
    start_div = 1'b1; op_signed = 1'b0; src1 = 32'd1000; src2 = 32'd3;
    for (int unsigned k = 0; k < 10; k++) push_s(c + k, 1'b1, "rst_mid_busy");
    repeat (10) tick();
    rstn = 1'b1; start_div = 1'b0;
    push_hl(cyc, '0, '0, "rst_mid_hilo");
    push_s(cyc, 1'b0, "rst_mid_sreq");
    m_hi = '0; m_lo = '0;
    tick();
    push_hl(cyc, '0, '0, "rst_mid_hilo_held");
    rstn = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic [31:0] a, b;
    tick(); tick();
    push_hl(cyc, '0, '0, "reset_hilo");
    push_s(cyc, 1'b0, "reset_sreq");
    tick();
    rstn = 1'b0;
    tick();

    do_write(1'b0, 1'b0, '0, '0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "mthi_mtlo");
    do_write(1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, '0, '0, 1'b0, "mult_neg2x3");
    do_write(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 1'b0, "multu_max");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0, "div_m7_2");
    do_div(1'b0, 32'd100, 32'd7, 1'b0, 0, 0, "divu_100_7");
    do_div(1'b0, 32'd5, 32'd0, 1'b0, 0, 0, "divu_by_zero");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, "div_overflow");
    do_div(1'b1, 32'h0123_4567, 32'h0000_0089, 1'b0, 15, 0, "div_flush15");
    do_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 0, 4, "div_done_stall4");
    do_div(1'b0, 32'd77, 32'd5, 1'b1, 0, 0, "div_with_whilo");
    do_write(1'b1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1,
             "mult_with_whilo");
    do_reset_mid();
    do_div(1'b0, 32'd7, 32'd2, 1'b0, 0, 0, "divu_7_2_after_rst");

    repeat (60) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (k <= 1) begin
        do_write(1'b0, 1'b0, '0, '0, a, b, 1'b0, "rand_whilo");
      end else if (k <= 4) begin
        do_write(1'b1, 1'($urandom_range(0, 1)), a, b, '0, '0, 1'($urandom_range(0, 1)),
                 "rand_mul");
      end else if (k <= 7) begin
        if ($urandom_range(0, 7) == 0) b = '0;
        else if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 100);
        do_div(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)), 0,
               $urandom_range(0, 2), "rand_div");
      end else if (k == 8) begin
        do_ignored($urandom_range(0, 2));
      end else begin
        tick();
      end
    end

    tick(); tick();
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL pending: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
